// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a 64-bit word memory.
// The read path waits READ_LAT cycles before presenting data. The write path accepts
// the address and data channels independently, then commits the write in one cycle.
// Out-of-range accesses return SLVERR and leave memory untouched.
module axi_lite_mem_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    // The byte span is 33 bits wide so that the in-range test also holds for very large depths.
    localparam logic [32:0] SPAN        = 33'd8 << DEPTH_LOG2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;

    logic [63:0] mem [DEPTH];

    rstate_t     rstate_q, rstate_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    wstate_t     wstate_q, wstate_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0]           ar_off, aw_off;
    logic                  ar_hit, aw_hit;
    logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
    logic                  mem_we;

    // The offset subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign ar_off = araddr_q - BASE_ADDR;
    assign aw_off = awaddr_q - BASE_ADDR;
    assign ar_hit = {1'b0, ar_off} < SPAN;
    assign aw_hit = {1'b0, aw_off} < SPAN;
    assign ar_idx = ar_off[DEPTH_LOG2+2:3];
    assign aw_idx = aw_off[DEPTH_LOG2+2:3];

    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign bresp = bresp_q;

    // Read FSM: next state, latency countdown and the read data register load.
    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        arready  = 1'b0;
        rvalid   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    araddr_d = araddr;
                    cnt_d    = 4'(READ_LAT);
                    rstate_d = R_WAIT;
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d  = ar_hit ? mem[ar_idx] : 64'd0;
                    rresp_d  = ar_hit ? RESP_OKAY : RESP_SLVERR;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Write FSM: independent AW/W capture, one-cycle commit, then hold the response.
    always_comb begin
        wstate_d = wstate_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready = !aw_got_q;
                wready  = !w_got_q;
                if (awvalid && !aw_got_q) begin
                    aw_got_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (wvalid && !w_got_q) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if (aw_got_d && w_got_d) wstate_d = W_COMMIT;
            end
            W_COMMIT: begin
                mem_we   = aw_hit;
                bresp_d  = aw_hit ? RESP_OKAY : RESP_SLVERR;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Control and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= 64'd0;
            rresp_q  <= 2'b00;
            wstate_q <= W_IDLE;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            rstate_q <= rstate_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            wstate_q <= wstate_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            bresp_q  <= bresp_d;
        end
    end

    // Captured address/data payload; only meaningful while the matching flag or state is set.
    always_ff @(posedge clk) begin
        araddr_q <= araddr_d;
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    // Byte-masked memory write; a same-cycle read load sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb_q[b]) mem[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: stimulus pushes expected R/B responses into
// queues; a negedge monitor pops and compares whenever a response handshake happens.
// A second instance with READ_LAT=3 shares the write channel and has its own read channel.
module tb_axi_lite_mem_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    logic [31:0] araddr3 = '0;
    logic        arvalid3 = 1'b0;
    logic        arready3;
    logic [63:0] rdata3;
    logic [1:0]  rresp3;
    logic        rvalid3;
    logic        rready3 = 1'b1;
    logic        awready3, wready3, bvalid3;
    logic [1:0]  bresp3;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } rexp_t;

    rexp_t      rq[$];
    rexp_t      r3q[$];
    logic [1:0] bq[$];
    logic [1:0] b3q[$];
    rexp_t      me, me3;
    logic [1:0] mb, mb3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_mem_slave #(.READ_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_lite_mem_slave #(.READ_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .araddr(araddr3), .arvalid(arvalid3), .arready(arready3),
        .rdata(rdata3), .rresp(rresp3), .rvalid(rvalid3), .rready(rready3),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready3),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready3),
        .bresp(bresp3), .bvalid(bvalid3), .bready(bready)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every completed R and B handshake with the queued expectation.
    always @(negedge clk) begin
        if (rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", 64'(rq.size()), 64'd1);
            else begin
                me = rq.pop_front();
                check("r_data", rdata, me.d);
                check("r_resp", 64'(rresp), 64'(me.r));
            end
        end
        if (rvalid3 && rready3) begin
            if (r3q.size() == 0) check("r3_unexpected", 64'(r3q.size()), 64'd1);
            else begin
                me3 = r3q.pop_front();
                check("r3_data", rdata3, me3.d);
                check("r3_resp", 64'(rresp3), 64'(me3.r));
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 64'(bq.size()), 64'd1);
            else begin
                mb = bq.pop_front();
                check("b_resp", 64'(bresp), 64'(mb));
            end
        end
        if (bvalid3 && bready) begin
            if (b3q.size() == 0) check("b3_unexpected", 64'(b3q.size()), 64'd1);
            else begin
                mb3 = b3q.pop_front();
                check("b3_resp", 64'(bresp3), 64'(mb3));
            end
        end
    end

    // Write with AW and W together (w_lead=0) or W issued w_lead cycles ahead of AW.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int w_lead, input logic [1:0] er);
        int n;
        bq.push_back(er);
        b3q.push_back(er);
        @(posedge clk); #1;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        if (w_lead > 0) begin
            @(negedge clk);
            check("w_first_ready", 64'(wready), 64'd1);
            @(posedge clk); #1;
            wvalid = 1'b0;
            for (int i = 1; i < w_lead; i++) begin
                @(negedge clk);
                check("w_ready_drop", 64'(wready), 64'd0);
                check("w_waits_aw", 64'(bvalid), 64'd0);
                @(posedge clk); #1;
            end
        end
        awaddr  = a;
        awvalid = 1'b1;
        @(negedge clk);
        check("aw_ready", 64'(awready), 64'd1);
        if (w_lead == 0) check("w_ready", 64'(wready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 1;
        @(negedge clk);
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", 64'(n), 64'd2);
    endtask

    // Read on the READ_LAT=1 instance; first rvalid is expected 2 cycles after AR.
    task automatic do_read(input logic [31:0] a, input logic [63:0] ed, input logic [1:0] er);
        int n;
        rexp_t e;
        e.d = ed;
        e.r = er;
        rq.push_back(e);
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        @(negedge clk);
        check("ar_ready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("r_latency", 64'(n), 64'd2);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    n;
        rexp_t e3;
        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_rresp", 64'(rresp), 64'd0);
        check("rst_bresp", 64'(bresp), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_arready", 64'(arready), 64'd1);
        check("post_rst_awready", 64'(awready), 64'd1);
        check("post_rst_wready", 64'(wready), 64'd1);

        // Same-cycle AW/W, full strobe, then readback.
        do_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 2'b00);
        do_read(32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);

        // W three cycles ahead of AW, low-half strobe.
        do_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3, 2'b00);
        do_read(32'h8000_0010, 64'h1122_3344_FFFF_FFFF, 2'b00);

        // Zero strobe completes OKAY and changes nothing.
        do_write(32'h8000_0010, 64'h0, 8'h00, 0, 2'b00);
        do_read(32'h8000_0010, 64'h1122_3344_FFFF_FFFF, 2'b00);

        // Sparse strobe on word 0; low address bits are ignored on readback.
        do_write(32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2'b00);
        do_write(32'h8000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 1, 2'b00);
        do_read(32'h8000_0007, 64'hAA23_4567_89AB_CDAA, 2'b00);

        // Last in-range word.
        do_write(32'h8000_1FF8, 64'h5555_5555_5555_5555, 8'hFF, 0, 2'b00);
        do_read(32'h8000_1FF8, 64'h5555_5555_5555_5555, 2'b00);

        // Just below base and just past the end: SLVERR, zero data, no memory change.
        do_read(32'h7FFF_FFF8, 64'h0, 2'b10);
        do_read(32'h8000_2000, 64'h0, 2'b10);
        do_write(32'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 2'b10);
        do_write(32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 2'b10);
        do_read(32'h8000_0000, 64'hAA23_4567_89AB_CDAA, 2'b00);
        do_read(32'h8000_1FF8, 64'h5555_5555_5555_5555, 2'b00);

        // Read load and write commit on the same word in the same cycle: read sees old data.
        do_write(32'h8000_0018, 64'h1111_1111_1111_1111, 8'hFF, 0, 2'b00);
        fork
            do_read(32'h8000_0018, 64'h1111_1111_1111_1111, 2'b00);
            do_write(32'h8000_0018, 64'h2222_2222_2222_2222, 8'hFF, 0, 2'b00);
        join
        do_read(32'h8000_0018, 64'h2222_2222_2222_2222, 2'b00);

        // READ_LAT=3 instance with rready held low for 5 cycles.
        e3.d = 64'h1122_3344_FFFF_FFFF;
        e3.r = 2'b00;
        r3q.push_back(e3);
        @(posedge clk); #1;
        rready3  = 1'b0;
        araddr3  = 32'h8000_0010;
        arvalid3 = 1'b1;
        @(negedge clk);
        check("ar3_ready", 64'(arready3), 64'd1);
        @(posedge clk); #1;
        arvalid3 = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rvalid3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("r3_latency", 64'(n), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check("r3_hold_valid", 64'(rvalid3), 64'd1);
            check("r3_hold_data", rdata3, 64'h1122_3344_FFFF_FFFF);
            check("r3_hold_arready", 64'(arready3), 64'd0);
            @(posedge clk); #1;
            if (i == 4) rready3 = 1'b1;
            @(negedge clk);
        end
        check("r3_hs_arready", 64'(arready3), 64'd0);
        @(posedge clk); #1;
        rready3 = 1'b0;
        @(negedge clk);
        check("r3_after_arready", 64'(arready3), 64'd1);
        check("r3_after_rvalid", 64'(rvalid3), 64'd0);

        // Reset while both instances sit in R_WAIT and W is captured without AW.
        @(posedge clk); #1;
        araddr   = 32'h8000_0010;
        arvalid  = 1'b1;
        araddr3  = 32'h8000_0010;
        arvalid3 = 1'b1;
        wdata    = 64'hDEAD_BEEF_DEAD_BEEF;
        wstrb    = 8'hFF;
        wvalid   = 1'b1;
        @(posedge clk); #1;
        arvalid  = 1'b0;
        arvalid3 = 1'b0;
        wvalid   = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("mid_w_captured", 64'(wready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check("mid_rst_arready", 64'(arready), 64'd1);
        check("mid_rst_awready", 64'(awready), 64'd1);
        check("mid_rst_wready", 64'(wready), 64'd1);
        check("mid_rst_rvalid3", 64'(rvalid3), 64'd0);
        check("mid_rst_arready3", 64'(arready3), 64'd1);
        check("mid_rst_awready3", 64'(awready3), 64'd1);
        check("mid_rst_wready3", 64'(wready3), 64'd1);
        repeat (4) begin
            @(negedge clk);
            check("mid_rst_quiet", 64'({rvalid, rvalid3, bvalid}), 64'd0);
        end
        do_read(32'h8000_0010, 64'h1122_3344_FFFF_FFFF, 2'b00);
        do_read(32'h8000_0018, 64'h2222_2222_2222_2222, 2'b00);

        // Reset landing on the commit cycle must not write.
        @(posedge clk); #1;
        awaddr  = 32'h8000_0010;
        awvalid = 1'b1;
        wdata   = 64'h0;
        wstrb   = 8'hFF;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("commit_rst_bvalid", 64'(bvalid), 64'd0);
        check("commit_rst_awready", 64'(awready), 64'd1);
        do_read(32'h8000_0010, 64'h1122_3344_FFFF_FFFF, 2'b00);

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(rq.size() + r3q.size() + bq.size() + b3q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
